// File: rtl/prefetch_mem_arbiter.sv
// Arbitrates the I-cache, D-cache and prefetch fill ports onto one cacheline adapter.
// Define PREFETCH_ARB_RR_EN to round-robin between the i and d demand ports (p stays lowest).
module prefetch_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    input  logic              p_read,
    input  logic [ADDR_W-1:0] p_addr,
    output logic              p_resp,
    output logic [LINE_W-1:0] p_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, GRANT_P} state_e;

    state_e state_q, state_d;
    logic   d_req;

    assign d_req = d_read | d_write;

    // Fill data is broadcast; only the owner's resp pulse qualifies it.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;
    assign p_rdata = pmem_rdata;

`ifdef PREFETCH_ARB_RR_EN
    // Set when d should win the next i/d contest; cleared state lets i win first.
    logic prio_d_q, prio_d_d;
`endif

    always_comb begin
        state_d    = state_q;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_addr  = '0;
        pmem_wdata = '0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        p_resp     = 1'b0;
`ifdef PREFETCH_ARB_RR_EN
        prio_d_d   = prio_d_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef PREFETCH_ARB_RR_EN
                if (d_req && (!i_read || prio_d_q)) begin
                    state_d  = GRANT_D;
                    prio_d_d = 1'b0;
                end else if (i_read) begin
                    state_d  = GRANT_I;
                    prio_d_d = 1'b1;
                end else if (p_read) begin
                    state_d  = GRANT_P;
                end
`else
                if (d_req)       state_d = GRANT_D;
                else if (i_read) state_d = GRANT_I;
                else if (p_read) state_d = GRANT_P;
`endif
            end
            GRANT_I: begin
                pmem_read  = i_read;
                pmem_addr  = i_addr;
                pmem_wdata = d_wdata;
                i_resp     = pmem_resp & ~rst;
                if (pmem_resp) state_d = IDLE;
            end
            GRANT_D: begin
                // Read and write together resolve to a write.
                pmem_read  = d_read & ~d_write;
                pmem_write = d_write;
                pmem_addr  = d_addr;
                pmem_wdata = d_wdata;
                d_resp     = pmem_resp & ~rst;
                if (pmem_resp) state_d = IDLE;
            end
            GRANT_P: begin
                pmem_read  = p_read;
                pmem_addr  = p_addr;
                pmem_wdata = d_wdata;
                p_resp     = pmem_resp & ~rst;
                if (pmem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
`ifdef PREFETCH_ARB_RR_EN
            prio_d_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
`ifdef PREFETCH_ARB_RR_EN
            prio_d_q <= prio_d_d;
`endif
        end
    end

endmodule

// File: tb/tb_prefetch_mem_arbiter.sv
// Bench for prefetch_mem_arbiter: directed scenarios then random traffic vs. an owner-tracking model.
module tb_prefetch_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read, d_read, d_write, p_read, pmem_resp;
    logic [ADDR_W-1:0] i_addr, d_addr, p_addr;
    logic [LINE_W-1:0] d_wdata, pmem_rdata;
    logic              i_resp, d_resp, p_resp, pmem_read, pmem_write;
    logic [LINE_W-1:0] i_rdata, d_rdata, p_rdata, pmem_wdata;
    logic [ADDR_W-1:0] pmem_addr;

    int    checks = 0;
    int    failures = 0;
    int    owner = 0;  // 0 none, 1 i, 2 d, 3 p
    bit    chk_en = 0;
    string log_s = "";

    always #5 clk = ~clk;

    prefetch_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .p_read(p_read), .p_addr(p_addr), .p_resp(p_resp), .p_rdata(p_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs mid-cycle against the model, then advance the model.
    task automatic step();
        logic              e_rd, e_wr, e_ir, e_dr, e_pr;
        logic [ADDR_W-1:0] e_addr;
        logic [LINE_W-1:0] e_wd;
        @(negedge clk);
        e_rd = (owner == 1) ? i_read : (owner == 2) ? (d_read & ~d_write) : (owner == 3) ? p_read : 1'b0;
        e_wr = (owner == 2) && d_write;
        e_addr = (owner == 1) ? i_addr : (owner == 2) ? d_addr : (owner == 3) ? p_addr : '0;
        e_wd = (owner != 0) ? d_wdata : '0;
        e_ir = (owner == 1) && pmem_resp && !rst;
        e_dr = (owner == 2) && pmem_resp && !rst;
        e_pr = (owner == 3) && pmem_resp && !rst;
        if (chk_en) begin
            chk("pmem_rw", {pmem_read, pmem_write}, {e_rd, e_wr});
            chk("rw_excl", pmem_read & pmem_write, 1'b0);
            chk("pmem_addr", pmem_addr, e_addr);
            chk("pmem_wdata", pmem_wdata, e_wd);
            chk("resp", {i_resp, d_resp, p_resp}, {e_ir, e_dr, e_pr});
            chk("rdata", {i_rdata ^ pmem_rdata} | {d_rdata ^ pmem_rdata} | {p_rdata ^ pmem_rdata}, '0);
        end
        if (i_resp) log_s = {log_s, "I"};
        if (d_resp) log_s = {log_s, "D"};
        if (p_resp) log_s = {log_s, "P"};
        @(posedge clk);
        if (rst) owner = 0;
        else if (owner != 0) begin
            if (pmem_resp) owner = 0;
        end else if (d_read || d_write) owner = 2;
        else if (i_read) owner = 1;
        else if (p_read) owner = 3;
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic chk_log(input string tag, input string exp);
        checks++;
        assert (log_s == exp) else begin
            failures++;
            $error("FAIL %s observed=%s expected=%s", tag, log_s, exp);
        end
        log_s = "";
    endtask

    initial begin
        rst = 1; i_read = 0; d_read = 0; d_write = 0; p_read = 0; pmem_resp = 0;
        i_addr = '0; d_addr = '0; p_addr = '0; d_wdata = '0; pmem_rdata = '0;
        step();
        chk_en = 1;
        step();
        rst = 0;
        steps(2);
        log_s = "";

        // Single i-cache fill, adapter answers after 5 cycles
        i_read = 1; i_addr = 32'h0000_1000; pmem_rdata = {8{32'hCAFE_F00D}};
        step();
        chk("i_grant_latency", {pmem_read, pmem_addr}, {1'b1, 32'h0000_1000});
        steps(4);
        pmem_resp = 1; step();
        pmem_resp = 0; i_read = 0; steps(2);
        chk_log("single_i", "I");

        // Simultaneous d_write, i_read, p_read: fixed order D, I, P
        d_write = 1; d_addr = 32'h0000_3000; d_wdata = {8{32'h1234_5678}};
        i_read = 1; i_addr = 32'h0000_1040; p_read = 1; p_addr = 32'h0000_2040;
        steps(3);
        pmem_resp = 1; step(); pmem_resp = 0; d_write = 0;
        steps(2);
        pmem_resp = 1; step(); pmem_resp = 0; i_read = 0;
        steps(2);
        pmem_resp = 1; step(); pmem_resp = 0; p_read = 0;
        steps(2);
        chk_log("order_dip", "DIP");

        // Prefetch granted, demand arrives 2 cycles later and must wait
        p_read = 1; p_addr = 32'h0000_2000;
        steps(2);
        d_read = 1; d_addr = 32'h0000_4000;
        steps(2);
        pmem_resp = 1; step(); pmem_resp = 0; p_read = 0;
        step();
        chk("d_after_p", {pmem_read, pmem_addr}, {1'b1, 32'h0000_4000});
        pmem_resp = 1; step(); pmem_resp = 0; d_read = 0;
        steps(2);
        chk_log("p_then_d", "PD");

        // Reset during GRANT_D abandons the access
        d_read = 1; d_addr = 32'h0000_5000;
        steps(2);
        rst = 1; step();
        rst = 0; d_read = 0;
        step();
        chk("rst_idle", {pmem_read, pmem_write, pmem_addr}, '0);
        steps(3);
        chk_log("rst_no_resp", "");

        // Owner drops its request early; arbiter still waits for pmem_resp
        i_read = 1; i_addr = 32'h0000_6000;
        steps(2);
        i_read = 0; d_read = 1;
        steps(3);
        pmem_resp = 1; step(); pmem_resp = 0;
        steps(2);
        pmem_resp = 1; step(); pmem_resp = 0; d_read = 0;
        step();
        chk_log("drop_early", "ID");

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            i_read = $urandom_range(0, 2) == 0;
            d_read = $urandom_range(0, 3) == 0;
            d_write = $urandom_range(0, 4) == 0;
            p_read = $urandom_range(0, 1) == 0;
            i_addr = $urandom; d_addr = $urandom; p_addr = $urandom;
            d_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pmem_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pmem_resp = $urandom_range(0, 3) == 0;
            rst = $urandom_range(0, 49) == 0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
